// File: rtl/result_drain.sv
// Result drain: snapshots the systolic array's N x N result matrix on done and
// streams it out one entry per valid/ready handshake with a write address.
module result_drain #(
   parameter int N         = 8,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 10,
   parameter int TRANSPOSE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  done,
   input  logic [N*N*DATA_W-1:0] c_flat,
   input  logic [ADDR_W-1:0]     base_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [ADDR_W-1:0]     out_addr,
   output logic                  out_last,
   output logic                  busy,
   output logic                  drain_done,
   output logic                  overrun
);

   localparam int NN    = N * N;
   localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;

   logic [0:0]        state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic              out_last_reg;
   logic              drain_done_reg;
   logic              overrun_reg;
   logic [DATA_W-1:0] buf_mem [NN];

   logic              streaming;
   logic              handshake;
   logic              final_hs;
   logic              capture;
   logic [IDX_W-1:0]  next_idx;
   logic [IDX_W-1:0]  rd_idx;

   always_comb begin
      streaming = (state_reg == S_STREAM);
      handshake = streaming & out_ready;
      final_hs  = handshake && (idx_reg == IDX_W'(NN - 1));
      // A done that lands on the final handshake is taken back-to-back
      capture   = done && (!streaming || final_hs);
      next_idx  = idx_reg + IDX_W'(1);
      rd_idx    = next_idx;
      if (TRANSPOSE != 0) begin
         rd_idx = IDX_W'((int'(next_idx) % N) * N + int'(next_idx) / N);
      end
   end

   // Shadow copy of the result matrix; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < NN; i++) begin
            buf_mem[i] <= c_flat[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         idx_reg        <= '0;
         base_reg       <= '0;
         out_data_reg   <= '0;
         out_addr_reg   <= '0;
         out_last_reg   <= 1'b0;
         drain_done_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         drain_done_reg <= final_hs;
         if (done && streaming && !final_hs) begin
            overrun_reg <= 1'b1;
         end
         if (capture) begin
            // Element 0 is C[0][0] in either order, so take it straight from the bus
            state_reg    <= S_STREAM;
            idx_reg      <= '0;
            base_reg     <= base_addr;
            out_data_reg <= c_flat[DATA_W-1:0];
            out_addr_reg <= base_addr;
            out_last_reg <= (NN == 1);
         end else if (final_hs) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            out_data_reg <= '0;
            out_addr_reg <= '0;
            out_last_reg <= 1'b0;
         end else if (handshake) begin
            idx_reg      <= next_idx;
            out_data_reg <= buf_mem[rd_idx];
            out_addr_reg <= base_reg + ADDR_W'(next_idx);
            out_last_reg <= (next_idx == IDX_W'(NN - 1));
         end
      end
   end

   assign out_valid  = streaming;
   assign busy       = streaming;
   assign out_data   = out_data_reg;
   assign out_addr   = out_addr_reg;
   assign out_last   = out_last_reg;
   assign drain_done = drain_done_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: row-major and transposed instances share stimulus.
module tb_result_drain;

   localparam int N  = 8;
   localparam int DW = 16;
   localparam int AW = 10;
   localparam int NN = N * N;

   logic              clk = 1'b0;
   logic              rst;
   logic              done;
   logic [NN*DW-1:0]  c_flat;
   logic [AW-1:0]     base_addr;
   logic              out_ready;

   logic              v0, l0, b0, dd0, ov0;
   logic [DW-1:0]     d0;
   logic [AW-1:0]     a0;
   logic              v1, l1, b1, dd1, ov1;
   logic [DW-1:0]     d1;
   logic [AW-1:0]     a1;

   int total = 0;
   int bad   = 0;

   result_drain #(.N(N), .DATA_W(DW), .ADDR_W(AW), .TRANSPOSE(0)) u_row (
      .clk(clk), .rst(rst), .done(done), .c_flat(c_flat), .base_addr(base_addr),
      .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_addr(a0),
      .out_last(l0), .busy(b0), .drain_done(dd0), .overrun(ov0)
   );

   result_drain #(.N(N), .DATA_W(DW), .ADDR_W(AW), .TRANSPOSE(1)) u_col (
      .clk(clk), .rst(rst), .done(done), .c_flat(c_flat), .base_addr(base_addr),
      .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_addr(a1),
      .out_last(l1), .busy(b1), .drain_done(dd1), .overrun(ov1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] base;
      bit            toggle;
      int            kind;
      int            exp_cycles;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int kind, input bit tr, input int k);
      int e;
      e = tr ? (k % N) * N + k / N : k;
      return (kind == 0) ? DW'(e) : DW'(e * 3 + 7);
   endfunction

   function automatic logic [NN*DW-1:0] mat(input int kind);
      logic [NN*DW-1:0] m;
      for (int i = 0; i < NN; i++) begin
         m[i*DW +: DW] = (kind == 0) ? DW'(i) : DW'(i * 3 + 7);
      end
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag, input bit with_ovr);
      chk({tag, " valid"}, 32'(v0), 0);
      chk({tag, " data"}, 32'(d0), 0);
      chk({tag, " addr"}, 32'(a0), 0);
      chk({tag, " last"}, 32'(l0), 0);
      chk({tag, " busy"}, 32'(b0), 0);
      chk({tag, " drain_done"}, 32'(dd0), 0);
      chk({tag, " t_valid"}, 32'(v1), 0);
      if (with_ovr) begin
         chk({tag, " overrun"}, 32'(ov0), 0);
         chk({tag, " t_overrun"}, 32'(ov1), 0);
      end
   endtask

   task automatic start(input logic [AW-1:0] b, input int kind);
      chk("idle before done", 32'(v0), 0);
      c_flat    = mat(kind);
      base_addr = b;
      done      = 1'b1;
      step();
      done   = 1'b0;
      c_flat = '1;
   endtask

   // Walks one stream, checking every cycle (stalled ones included) against
   // the element the consumer has not yet accepted.
   task automatic collect(input logic [AW-1:0] b, input int kind, input bit toggle,
                          input int done_at, input int done_kind,
                          input logic [AW-1:0] done_base, output int cycles);
      int k;
      int cyc;
      logic [AW-1:0] ea;
      k   = 0;
      cyc = 0;
      while (k < NN && cyc < 400) begin
         out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
         if (k == done_at && out_ready) begin
            done      = 1'b1;
            c_flat    = mat(done_kind);
            base_addr = done_base;
         end
         ea = b + AW'(k);
         chk($sformatf("valid k=%0d", k), 32'(v0), 1);
         chk($sformatf("data k=%0d", k), 32'(d0), 32'(exp_data(kind, 1'b0, k)));
         chk($sformatf("addr k=%0d", k), 32'(a0), 32'(ea));
         chk($sformatf("last k=%0d", k), 32'(l0), 32'(k == NN - 1));
         chk($sformatf("t_data k=%0d", k), 32'(d1), 32'(exp_data(kind, 1'b1, k)));
         if (out_ready) k++;
         step();
         done   = 1'b0;
         c_flat = '1;
         cyc++;
      end
      chk("stream completes within budget", 32'(k), NN);
      $display("stream base=%0d kind=%0d toggle=%0d beats=%0d cycles=%0d", b, kind, toggle, k, cyc);
      cycles = cyc;
   endtask

   initial begin
      vec_t tbl[3];
      int cycles;

      tbl[0] = '{base: 10'd0,    toggle: 1'b0, kind: 0, exp_cycles: 64};
      tbl[1] = '{base: 10'd1020, toggle: 1'b0, kind: 1, exp_cycles: 64};
      tbl[2] = '{base: 10'd0,    toggle: 1'b1, kind: 0, exp_cycles: 128};

      rst = 1'b1; done = 1'b0; out_ready = 1'b0; c_flat = '0; base_addr = '0;
      step();
      step();
      check_zero("reset", 1'b1);
      rst = 1'b0;
      step();
      check_zero("idle after reset", 1'b1);

      for (int t = 0; t < 3; t++) begin
         start(tbl[t].base, tbl[t].kind);
         collect(tbl[t].base, tbl[t].kind, tbl[t].toggle, -1, 0, '0, cycles);
         chk($sformatf("vec%0d cycles", t), 32'(cycles), 32'(tbl[t].exp_cycles));
         chk($sformatf("vec%0d drain_done", t), 32'(dd0), 1);
         chk($sformatf("vec%0d t_drain_done", t), 32'(dd1), 1);
         chk($sformatf("vec%0d valid after", t), 32'(v0), 0);
         chk($sformatf("vec%0d busy after", t), 32'(b0), 0);
         chk($sformatf("vec%0d overrun", t), 32'(ov0), 0);
         step();
         chk($sformatf("vec%0d drain_done pulse", t), 32'(dd0), 0);
      end

      // done mid-stream: dropped, flagged, snapshot untouched
      start(10'd0, 0);
      collect(10'd0, 0, 1'b0, 10, 1, 10'd500, cycles);
      chk("overrun set", 32'(ov0), 1);
      chk("t_overrun set", 32'(ov1), 1);
      chk("overrun drain_done", 32'(dd0), 1);
      step();
      chk("overrun idle after", 32'(v0), 0);

      // done on the final handshake: next stream follows with no gap
      start(10'd0, 0);
      collect(10'd0, 0, 1'b0, 63, 1, 10'd100, cycles);
      chk("b2b first cycles", 32'(cycles), 64);
      chk("b2b drain_done", 32'(dd0), 1);
      chk("b2b valid no gap", 32'(v0), 1);
      collect(10'd100, 1, 1'b0, -1, 0, '0, cycles);
      chk("b2b second cycles", 32'(cycles), 64);
      chk("b2b second drain_done", 32'(dd0), 1);
      chk("b2b second idle", 32'(v0), 0);

      // Reset in the middle of a stream
      start(10'd5, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) step();
      chk("pre-reset beat30 addr", 32'(a0), 35);
      rst = 1'b1;
      step();
      check_zero("mid-stream reset", 1'b1);
      rst = 1'b0;
      step();
      check_zero("idle after mid reset", 1'b0);
      start(10'd7, 0);
      collect(10'd7, 0, 1'b0, -1, 0, '0, cycles);
      chk("restart cycles", 32'(cycles), 64);
      chk("restart drain_done", 32'(dd0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
